// File: rtl/ir_prefix_tracker.sv
// Opcode prefix tracker: folds DD/FD/CB/ED prefix bytes and the DD/FD CB displacement into ir/prefix for pla_decode.
// Latency: 1 clk from byte_valid to registered ir/prefix/ir_valid/prefix_busy.
// Backpressure: none; accepts one byte per cycle, prefix_busy tells the sequencer to fetch another byte.
module ir_prefix_tracker #(
    parameter logic [7:0] NOP_OPCODE = 8'h00
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       instr_done,
    output logic [7:0] ir,
    output logic [4:0] prefix,
    output logic       use_iy,
    output logic [7:0] disp,
    output logic       disp_valid,
    output logic       ir_valid,
    output logic       prefix_busy
);

    typedef enum logic [2:0] {
        S_BASE,
        S_IXY,
        S_CB,
        S_ED,
        S_XYCB_D,
        S_XYCB_OP
    } state_t;

    localparam logic [7:0] BYTE_DD = 8'hDD;
    localparam logic [7:0] BYTE_FD = 8'hFD;
    localparam logic [7:0] BYTE_CB = 8'hCB;
    localparam logic [7:0] BYTE_ED = 8'hED;

    // prefix bus layout: {~ixy, ixy, tblXX, tblCB, tblED}
    localparam logic [4:0] PFX_BASE = 5'b10100;
    localparam logic [4:0] PFX_XY   = 5'b01100;
    localparam logic [4:0] PFX_CB   = 5'b10010;
    localparam logic [4:0] PFX_ED   = 5'b10001;
    localparam logic [4:0] PFX_XYED = 5'b01001;
    localparam logic [4:0] PFX_XYCB = 5'b01010;

    state_t     state, state_nxt, eff_state;
    logic       ixy, ixy_nxt, eff_ixy;
    logic [7:0] ir_nxt;
    logic [4:0] prefix_nxt;
    logic       use_iy_nxt;
    logic [7:0] disp_nxt;
    logic       disp_valid_nxt;
    logic       ir_valid_nxt;
    logic       prefix_busy_nxt;
    logic       is_xy;

    assign is_xy = (byte_in == BYTE_DD) || (byte_in == BYTE_FD);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= S_BASE;
            ixy         <= 1'b0;
            ir          <= NOP_OPCODE;
            prefix      <= PFX_BASE;
            use_iy      <= 1'b0;
            disp        <= 8'h00;
            disp_valid  <= 1'b0;
            ir_valid    <= 1'b0;
            prefix_busy <= 1'b0;
        end else begin
            state       <= state_nxt;
            ixy         <= ixy_nxt;
            ir          <= ir_nxt;
            prefix      <= prefix_nxt;
            use_iy      <= use_iy_nxt;
            disp        <= disp_nxt;
            disp_valid  <= disp_valid_nxt;
            ir_valid    <= ir_valid_nxt;
            prefix_busy <= prefix_busy_nxt;
        end
    end

    // instr_done is applied first, so a byte arriving with it decodes from BASE
    always_comb begin
        eff_state      = instr_done ? S_BASE : state;
        eff_ixy        = instr_done ? 1'b0 : ixy;
        state_nxt      = eff_state;
        ixy_nxt        = eff_ixy;
        ir_nxt         = instr_done ? NOP_OPCODE : ir;
        prefix_nxt     = instr_done ? PFX_BASE : prefix;
        use_iy_nxt     = use_iy;
        disp_nxt       = disp;
        disp_valid_nxt = instr_done ? 1'b0 : disp_valid;
        ir_valid_nxt   = 1'b0;

        if (byte_valid) begin
            case (eff_state)
                S_BASE: begin
                    // a new instruction starts here, so any earlier displacement is stale
                    disp_valid_nxt = 1'b0;
                    if (is_xy) begin
                        state_nxt  = S_IXY;
                        ixy_nxt    = 1'b1;
                        use_iy_nxt = byte_in[5];
                    end else if (byte_in == BYTE_CB) begin
                        state_nxt = S_CB;
                    end else if (byte_in == BYTE_ED) begin
                        state_nxt = S_ED;
                    end else begin
                        ir_nxt       = byte_in;
                        prefix_nxt   = PFX_BASE;
                        ir_valid_nxt = 1'b1;
                    end
                end
                S_IXY: begin
                    if (is_xy) begin
                        use_iy_nxt = byte_in[5];
                    end else if (byte_in == BYTE_CB) begin
                        state_nxt = S_XYCB_D;
                    end else if (byte_in == BYTE_ED) begin
                        state_nxt = S_ED;
                    end else begin
                        ir_nxt       = byte_in;
                        prefix_nxt   = PFX_XY;
                        ir_valid_nxt = 1'b1;
                        ixy_nxt      = 1'b0;
                        state_nxt    = S_BASE;
                    end
                end
                S_CB: begin
                    ir_nxt       = byte_in;
                    prefix_nxt   = PFX_CB;
                    ir_valid_nxt = 1'b1;
                    state_nxt    = S_BASE;
                end
                S_ED: begin
                    ir_nxt       = byte_in;
                    prefix_nxt   = eff_ixy ? PFX_XYED : PFX_ED;
                    ir_valid_nxt = 1'b1;
                    ixy_nxt      = 1'b0;
                    state_nxt    = S_BASE;
                end
                S_XYCB_D: begin
                    disp_nxt       = byte_in;
                    disp_valid_nxt = 1'b1;
                    state_nxt      = S_XYCB_OP;
                end
                S_XYCB_OP: begin
                    ir_nxt       = byte_in;
                    prefix_nxt   = PFX_XYCB;
                    ir_valid_nxt = 1'b1;
                    ixy_nxt      = 1'b0;
                    state_nxt    = S_BASE;
                end
                default: begin
                    state_nxt = S_BASE;
                    ixy_nxt   = 1'b0;
                end
            endcase
        end

        prefix_busy_nxt = (state_nxt != S_BASE);
    end

endmodule

// File: tb/tb_ir_prefix_tracker.sv
// Bench for ir_prefix_tracker: directed scenarios plus random byte streams against a byte-sequence model.
module tb_ir_prefix_tracker;

    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       instr_done;
    logic [7:0] ir;
    logic [4:0] prefix;
    logic       use_iy;
    logic [7:0] disp;
    logic       disp_valid;
    logic       ir_valid;
    logic       prefix_busy;

    int checks = 0;
    int failures = 0;

    // model: bytes of the instruction in progress, parsed as a whole on each new byte
    logic [7:0] m_q[$];
    logic [7:0] m_ir;
    logic [4:0] m_prefix;
    logic       m_use_iy;
    logic [7:0] m_disp;
    logic       m_dv;
    logic       m_irv;
    logic       m_busy;

    always #5 clk = ~clk;

    ir_prefix_tracker #(.NOP_OPCODE(8'h00)) dut (
        .clk(clk), .nreset(nreset), .byte_in(byte_in), .byte_valid(byte_valid),
        .instr_done(instr_done), .ir(ir), .prefix(prefix), .use_iy(use_iy),
        .disp(disp), .disp_valid(disp_valid), .ir_valid(ir_valid), .prefix_busy(prefix_busy)
    );

    task automatic model_reset();
        m_q.delete();
        m_ir = 8'h00; m_prefix = 5'b10100; m_use_iy = 1'b0;
        m_disp = 8'h00; m_dv = 1'b0; m_irv = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_step(input logic bv, input logic [7:0] b, input logic done);
        int i;
        int rlen;
        logic xy;
        logic complete;
        m_irv = 1'b0;
        if (done) begin
            m_q.delete();
            m_ir = 8'h00; m_prefix = 5'b10100; m_dv = 1'b0;
        end
        if (bv) begin
            if (m_q.size() == 0) m_dv = 1'b0;
            m_q.push_back(b);
            i = 0; xy = 1'b0; complete = 1'b0;
            while (i < m_q.size() && (m_q[i] == 8'hDD || m_q[i] == 8'hFD)) begin
                xy = 1'b1;
                i++;
            end
            rlen = m_q.size() - i;
            if (rlen == 0) begin
                m_use_iy = b[5];
            end else if (m_q[i] == 8'hCB) begin
                if (xy && rlen == 2) begin
                    m_disp = b; m_dv = 1'b1;
                end else if (xy && rlen == 3) begin
                    m_ir = b; m_prefix = 5'b01010; complete = 1'b1;
                end else if (!xy && rlen == 2) begin
                    m_ir = b; m_prefix = 5'b10010; complete = 1'b1;
                end
            end else if (m_q[i] == 8'hED) begin
                if (rlen == 2) begin
                    m_ir = b; m_prefix = xy ? 5'b01001 : 5'b10001; complete = 1'b1;
                end
            end else begin
                m_ir = b; m_prefix = xy ? 5'b01100 : 5'b10100; complete = 1'b1;
            end
            if (complete) begin
                m_q.delete();
                m_irv = 1'b1;
            end
        end
        m_busy = (m_q.size() != 0);
    endtask

    // drive at negedge, let one posedge pass, leave time #1 after it for sampling
    task automatic step(input logic bv, input logic [7:0] b, input logic done);
        @(negedge clk);
        byte_valid = bv; byte_in = b; instr_done = done;
        @(posedge clk);
        model_step(bv, b, done);
        #1;
        byte_valid = 1'b0; instr_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        byte_valid = 1'b0; instr_done = 1'b0; byte_in = 8'h00; nreset = 1'b0;
        model_reset();
        #12;
        checks++; if (ir !== 8'h00) begin failures++; $display("FAIL reset_ir got=%h exp=00", ir); end
        checks++; if (prefix !== 5'b10100) begin failures++; $display("FAIL reset_prefix got=%b exp=10100", prefix); end
        checks++; if ({use_iy, disp_valid, ir_valid, prefix_busy} !== 4'b0000 || disp !== 8'h00)
            begin failures++; $display("FAIL reset_flags got=%b disp=%h exp=0000 disp=00", {use_iy, disp_valid, ir_valid, prefix_busy}, disp); end
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_plain();
        step(1'b1, 8'h3E, 1'b0);
        checks++; if (ir !== 8'h3E || prefix !== 5'b10100) begin failures++; $display("FAIL plain_ir got=%h/%b exp=3e/10100", ir, prefix); end
        checks++; if (ir_valid !== 1'b1 || prefix_busy !== 1'b0) begin failures++; $display("FAIL plain_flags got=%b%b exp=10", ir_valid, prefix_busy); end
        step(1'b0, 8'h00, 1'b0);
        checks++; if (ir_valid !== 1'b0 || ir !== 8'h3E) begin failures++; $display("FAIL plain_pulse got=%b ir=%h exp=0 ir=3e", ir_valid, ir); end
    endtask

    task automatic test_index();
        logic [7:0] pfx_byte;
        for (int k = 0; k < 2; k++) begin
            pfx_byte = (k == 0) ? 8'hDD : 8'hFD;
            step(1'b1, pfx_byte, 1'b0);
            checks++; if (prefix_busy !== 1'b1 || ir_valid !== 1'b0) begin failures++; $display("FAIL index_busy k=%0d got=%b%b exp=10", k, prefix_busy, ir_valid); end
            step(1'b1, 8'h21, 1'b0);
            checks++; if (ir !== 8'h21 || prefix !== 5'b01100 || use_iy !== k[0])
                begin failures++; $display("FAIL index_op k=%0d got=%h/%b/%b exp=21/01100/%b", k, ir, prefix, use_iy, k[0]); end
            step(1'b1, 8'h00, 1'b1);
        end
    endtask

    task automatic test_indexed_cb();
        logic [7:0] seq[4];
        int pulses = 0;
        seq[0] = 8'hFD; seq[1] = 8'hCB; seq[2] = 8'h05; seq[3] = 8'h46;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, seq[k], 1'b0);
            if (ir_valid) pulses++;
            if (k == 2) begin
                checks++; if (disp !== 8'h05 || disp_valid !== 1'b1 || prefix_busy !== 1'b1)
                    begin failures++; $display("FAIL xycb_disp got=%h/%b/%b exp=05/1/1", disp, disp_valid, prefix_busy); end
            end
        end
        checks++; if (ir !== 8'h46 || prefix !== 5'b01010 || use_iy !== 1'b1)
            begin failures++; $display("FAIL xycb_op got=%h/%b/%b exp=46/01010/1", ir, prefix, use_iy); end
        checks++; if (pulses != 1 || ir_valid !== 1'b1) begin failures++; $display("FAIL xycb_pulses got=%0d exp=1", pulses); end
        step(1'b1, 8'h00, 1'b1);
        checks++; if (disp_valid !== 1'b0 || ir !== 8'h00) begin failures++; $display("FAIL done_clear got=%b ir=%h exp=0 ir=00", disp_valid, ir); end
    endtask

    task automatic test_ed();
        step(1'b1, 8'hED, 1'b0); step(1'b1, 8'hB0, 1'b0);
        checks++; if (ir !== 8'hB0 || prefix !== 5'b10001) begin failures++; $display("FAIL ed_plain got=%h/%b exp=b0/10001", ir, prefix); end
        step(1'b1, 8'hDD, 1'b0); step(1'b1, 8'hED, 1'b0); step(1'b1, 8'h4A, 1'b0);
        checks++; if (ir !== 8'h4A || prefix !== 5'b01001) begin failures++; $display("FAIL ed_ixy got=%h/%b exp=4a/01001", ir, prefix); end
        step(1'b1, 8'hED, 1'b0); step(1'b1, 8'hDD, 1'b0);
        checks++; if (ir !== 8'hDD || prefix !== 5'b10001 || prefix_busy !== 1'b0 || ir_valid !== 1'b1)
            begin failures++; $display("FAIL ed_dd got=%h/%b/%b%b exp=dd/10001/01", ir, prefix, prefix_busy, ir_valid); end
    endtask

    task automatic test_chained();
        step(1'b1, 8'hDD, 1'b0); step(1'b1, 8'hFD, 1'b0); step(1'b1, 8'hDD, 1'b0); step(1'b1, 8'h7E, 1'b0);
        checks++; if (ir !== 8'h7E || prefix !== 5'b01100 || use_iy !== 1'b0)
            begin failures++; $display("FAIL chain_xy got=%h/%b/%b exp=7e/01100/0", ir, prefix, use_iy); end
        step(1'b1, 8'hCB, 1'b0); step(1'b1, 8'hDD, 1'b0);
        checks++; if (ir !== 8'hDD || prefix !== 5'b10010 || prefix_busy !== 1'b0)
            begin failures++; $display("FAIL chain_cb got=%h/%b/%b exp=dd/10010/0", ir, prefix, prefix_busy); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'hFD, 1'b0); step(1'b1, 8'hCB, 1'b0);
        #2;
        nreset = 1'b0;
        #1;
        model_reset();
        checks++; if (ir !== 8'h00 || prefix !== 5'b10100 || disp !== 8'h00 ||
                      {use_iy, disp_valid, ir_valid, prefix_busy} !== 4'b0000)
            begin failures++; $display("FAIL async_reset got=%h/%b/%h/%b", ir, prefix, disp, {use_iy, disp_valid, ir_valid, prefix_busy}); end
        @(negedge clk);
        nreset = 1'b1;
        step(1'b1, 8'h46, 1'b0);
        checks++; if (ir !== 8'h46 || prefix !== 5'b10100) begin failures++; $display("FAIL after_reset got=%h/%b exp=46/10100", ir, prefix); end
    endtask

    task automatic test_done_same_cycle();
        step(1'b1, 8'hDD, 1'b0);
        step(1'b1, 8'hCB, 1'b1);
        checks++; if (prefix_busy !== 1'b1 || ir !== 8'h00 || prefix !== 5'b10100 || ir_valid !== 1'b0)
            begin failures++; $display("FAIL done_cb got=%b/%h/%b/%b exp=1/00/10100/0", prefix_busy, ir, prefix, ir_valid); end
        step(1'b1, 8'h46, 1'b0);
        checks++; if (ir !== 8'h46 || prefix !== 5'b10010) begin failures++; $display("FAIL done_cb_op got=%h/%b exp=46/10010", ir, prefix); end
        step(1'b1, 8'hDD, 1'b1);
        checks++; if (prefix_busy !== 1'b1 || use_iy !== 1'b0) begin failures++; $display("FAIL done_dd got=%b/%b exp=1/0", prefix_busy, use_iy); end
        step(1'b1, 8'h00, 1'b1);
    endtask

    task automatic test_gaps();
        step(1'b1, 8'hFD, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h21, 1'b0);
            checks++; if (prefix_busy !== 1'b1 || ir_valid !== 1'b0) begin failures++; $display("FAIL gap_idle k=%0d got=%b%b exp=10", k, prefix_busy, ir_valid); end
        end
        step(1'b1, 8'h21, 1'b0);
        checks++; if (ir !== 8'h21 || prefix !== 5'b01100 || use_iy !== 1'b1 || ir_valid !== 1'b1)
            begin failures++; $display("FAIL gap_op got=%h/%b/%b/%b exp=21/01100/1/1", ir, prefix, use_iy, ir_valid); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic bv, dn;
        int sel;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 8'hDD;
                1: b = 8'hFD;
                2: b = 8'hCB;
                3: b = 8'hED;
                default: b = 8'($urandom);
            endcase
            bv = ($urandom_range(0, 3) != 0);
            dn = ($urandom_range(0, 11) == 0);
            step(bv, b, dn);
            checks++;
            if (ir !== m_ir || prefix !== m_prefix || use_iy !== m_use_iy || disp !== m_disp ||
                disp_valid !== m_dv || ir_valid !== m_irv || prefix_busy !== m_busy) begin
                failures++;
                $display("FAIL random n=%0d got ir=%h pfx=%b iy=%b d=%h dv=%b v=%b busy=%b exp ir=%h pfx=%b iy=%b d=%h dv=%b v=%b busy=%b",
                         n, ir, prefix, use_iy, disp, disp_valid, ir_valid, prefix_busy,
                         m_ir, m_prefix, m_use_iy, m_disp, m_dv, m_irv, m_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_index();
        test_indexed_cb();
        test_ed();
        test_chained();
        test_async_reset();
        test_done_same_cycle();
        test_gaps();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_prefix_tracker.md
Name: ir_prefix_tracker

Overview:
Sequential front end for pla_decode. It consumes the opcode stream byte by byte and tracks DD/FD/CB/ED prefixes, including the DD/FD CB d op displacement slot. It drives the registered ir[7:0] and prefix[4:0] buses that pla_decode consumes. It sits between the data-bus latch and pla_decode, and is sequenced by the execute/sequencer logic.

Parameters:
NOP_OPCODE, 8'h00, IR value loaded at reset and on instr_done.

Ports:
clk  input  1  system clock
nreset  input  1  asynchronous active-low reset
byte_in  input  8  fetched byte (opcode, prefix or displacement)
byte_valid  input  1  byte_in is valid this cycle; one byte per cycle max
instr_done  input  1  current instruction complete; return to base table
ir  output  8  opcode to pla_decode
prefix  output  5  {~ixy, ixy, tblXX, tblCB, tblED} to pla_decode
use_iy  output  1  1 = FD seen (IY), 0 = DD seen (IX); valid while prefix[3]=1
disp  output  8  captured displacement for DD/FD CB forms
disp_valid  output  1  disp holds a fresh displacement for current instruction
ir_valid  output  1  one-cycle pulse: ir/prefix now hold a complete opcode
prefix_busy  output  1  prefix sequence in progress; sequencer must fetch another byte

Behaviour:
- Reset (async, nreset=0): state=BASE, ir=NOP_OPCODE, prefix=5'b10100, use_iy=0, disp=0, disp_valid=0, ir_valid=0, prefix_busy=0. Deassertion is synchronous to clk in the surrounding design; no internal synchronizer.
- All outputs are registered. Latency is 1 clk from byte_valid to the updated ir/prefix/ir_valid/prefix_busy.
- States: BASE, IXY, CB, ED, XYCB_D, XYCB_OP.
- BASE + byte:
  - DD or FD -> IXY; use_iy=byte[5]; prefix_busy=1.
  - CB -> CB; prefix_busy=1.
  - ED -> ED; prefix_busy=1.
  - else -> ir=byte, prefix=10100, ir_valid=1; stay BASE.
- IXY + byte:
  - DD/FD -> stay IXY; use_iy updated (last prefix wins).
  - CB -> XYCB_D.
  - ED -> ED with ixy kept.
  - else -> ir=byte, prefix=01100, ir_valid=1, go to BASE.
- CB + byte: ir=byte, prefix=10010, ir_valid=1 -> BASE. No prefix interpretation.
- ED + byte: ir=byte, prefix = ixy ? 01001 : 10001, ir_valid=1 -> BASE. ED DD / ED FD are opcodes, not prefixes.
- XYCB_D + byte: disp=byte, disp_valid=1 -> XYCB_OP; prefix_busy stays 1.
- XYCB_OP + byte: ir=byte, prefix=01010, ir_valid=1 -> BASE.
- prefix_busy=1 in IXY/CB/ED/XYCB_D/XYCB_OP, else 0. ir and prefix hold their last value while a prefix sequence is in progress.
- ir_valid is high for exactly 1 clk per completed opcode. It is 0 when byte_valid=0.
- The ixy flag is cleared whenever state returns to BASE via an opcode. ir/prefix/use_iy/disp then hold until the next load.
- instr_done:
  - Forces state=BASE, prefix=10100, ir=NOP_OPCODE, disp_valid=0.
  - Same cycle as byte_valid: instr_done applies first, then byte_in is decoded from BASE. Example: done+DD -> IXY.
- Reset mid-sequence (e.g. in XYCB_D) discards all captured state.

Test Plan:
- Plain: reset; byte 3E -> next clk ir=3E, prefix=10100, ir_valid=1 for 1 clk, prefix_busy=0.
- Index: DD then 21 -> after DD prefix_busy=1, ir_valid=0; after 21 ir=21, prefix=01100, use_iy=0. Repeat with FD, 21 -> use_iy=1.
- Indexed CB: FD, CB, 05, 46 -> disp=05, disp_valid=1 after 3rd byte; after 4th ir=46, prefix=01010, use_iy=1, ir_valid pulse only once across the sequence.
- ED forms: ED, B0 -> prefix=10001, ir=B0. DD, ED, 4A -> prefix=01001. ED, DD -> ir=DD, prefix=10001, state BASE.
- Chained prefixes: DD, FD, DD, 7E -> use_iy=0, prefix=01100, ir=7E. CB, DD -> ir=DD, prefix=10010.
- Boundaries:
  - nreset low while in XYCB_D -> all outputs at reset values immediately (async).
  - instr_done with byte_valid=1, byte CB -> state CB, prefix_busy=1, ir=00.
  - byte_valid gaps of 3 clks between prefix and opcode -> result identical to back-to-back bytes.
